gt1_loader: RTL and testbench

- Parses a GT1 program image streamed over the HPS ioctl download channel.
- Emits one RAM write per payload byte through a req/ack handshake, and reports the program start address.
- Sits upstream of the Gigatron core: it feeds the core's RAM write port, and its start address drives the core's program launch.
- All logic runs on clk_sys.

---
 rtl/gt1_loader.sv | 144 ++++++++++++++
 tb/tb_gt1_loader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gt1_loader.sv
// GT1 image loader: parses a GT1 program streamed over the ioctl download
// channel, issues one RAM write per payload byte via req/ack, and reports
// the execution address found in the trailer.
module gt1_loader #(
  parameter logic [7:0]  GT1_INDEX = 8'h01,
  parameter logic [24:0] MAX_BYTES = 25'h1_0000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic        ioctl_wait,
  output logic        ram_req,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_data,
  input  logic        ram_ack,
  output logic [15:0] start_addr,
  output logic        start_valid,
  output logic        busy,
  output logic        error
);

  typedef enum logic [3:0] {
    IDLE, SEG_HI, SEG_LO, SEG_SIZE, DATA, START_HI, START_LO, DONE, ERROR
  } state_t;

  state_t      state;
  logic [24:0] count;       // expected ioctl_addr of the next accepted byte
  logic [7:0]  page;
  logic [7:0]  lo;
  logic [8:0]  rem;         // bytes left in segment, 1..256
  logic        seg_seen;    // at least one segment completed
  logic        trunc_pend;  // download ended while a write was outstanding
  logic        dl_q;
  logic        gt1_dl_q;

  logic gt1_dl, start, accept, parsing, trunc, addr_bad;

  assign gt1_dl   = ioctl_download && (ioctl_index == GT1_INDEX);
  assign start    = gt1_dl && !gt1_dl_q;
  assign accept   = gt1_dl && ioctl_wr && !ioctl_wait;
  assign parsing  = state inside {SEG_HI, SEG_LO, SEG_SIZE, DATA, START_HI, START_LO};
  assign trunc    = dl_q && !ioctl_download && parsing;
  assign addr_bad = (ioctl_addr != count) || (ioctl_addr >= MAX_BYTES);

  // Status flags are pure decodes of the state register; ERROR and DONE are
  // only left on a new transfer, so error/start_valid hold until then.
  assign busy        = parsing;
  assign error       = (state == ERROR);
  assign start_valid = (state == DONE);

  // Parser FSM, download edge tracking and RAM write handshake.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      page       <= '0;
      lo         <= '0;
      rem        <= '0;
      seg_seen   <= 1'b0;
      trunc_pend <= 1'b0;
      dl_q       <= 1'b0;
      gt1_dl_q   <= 1'b0;
      ioctl_wait <= 1'b0;
      ram_req    <= 1'b0;
      ram_addr   <= '0;
      ram_data   <= '0;
      start_addr <= '0;
    end else begin
      dl_q     <= ioctl_download;
      gt1_dl_q <= gt1_dl;
      if (start) begin
        // A new GT1 transfer restarts parsing from any state and abandons
        // any in-flight write.
        state      <= SEG_HI;
        count      <= '0;
        seg_seen   <= 1'b0;
        trunc_pend <= 1'b0;
        ram_req    <= 1'b0;
        ioctl_wait <= 1'b0;
      end else if (ram_req) begin
        // Outstanding write: truncation is deferred until the ack.
        if (trunc) trunc_pend <= 1'b1;
        if (ram_ack) begin
          ram_req    <= 1'b0;
          ioctl_wait <= 1'b0;
          lo         <= lo + 8'd1;
          rem        <= rem - 9'd1;
          if (trunc || trunc_pend) begin
            state <= ERROR;
          end else if (rem == 9'd1) begin
            seg_seen <= 1'b1;
            state    <= SEG_HI;
          end
        end
      end else if (trunc) begin
        state <= ERROR;
      end else if (accept && parsing) begin
        if (addr_bad) begin
          state <= ERROR;
        end else begin
          count <= count + 25'd1;
          case (state)
            SEG_HI: begin
              if (ioctl_dout == 8'h00 && seg_seen) begin
                state <= START_HI;
              end else begin
                page  <= ioctl_dout;
                state <= SEG_LO;
              end
            end
            SEG_LO: begin
              lo    <= ioctl_dout;
              state <= SEG_SIZE;
            end
            SEG_SIZE: begin
              rem   <= (ioctl_dout == 8'h00) ? 9'd256 : {1'b0, ioctl_dout};
              state <= DATA;
            end
            DATA: begin
              ram_addr   <= {page, lo};
              ram_data   <= ioctl_dout;
              ram_req    <= 1'b1;
              ioctl_wait <= 1'b1;
            end
            START_HI: begin
              start_addr[15:8] <= ioctl_dout;
              state            <= START_LO;
            end
            START_LO: begin
              start_addr[7:0] <= ioctl_dout;
              state           <= DONE;
            end
            default: state <= state;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_gt1_loader.sv
// Directed bench for gt1_loader: table-driven minimal image plus
// hand-written sequences for page wrap, back-pressure, truncation,
// index filtering, restart and reset.
module tb_gt1_loader;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [7:0]  ioctl_index = '0;
  logic        ioctl_wait;
  logic        ram_req;
  logic [15:0] ram_addr;
  logic [7:0]  ram_data;
  logic        ram_ack = 1'b0;
  logic [15:0] start_addr;
  logic        start_valid;
  logic        busy;
  logic        error;

  gt1_loader dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait),
    .ram_req(ram_req), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_ack(ram_ack), .start_addr(start_addr),
    .start_valid(start_valid), .busy(busy), .error(error)
  );

  always #5 clk_sys = ~clk_sys;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0]  b;
    int          nwr;
    logic [23:0] wr;
    logic        busy;
  } vec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          ack_delay = 0;
  int          ack_cnt = 0;
  int          wait_hi = 0;
  int          viol = 0;
  logic [23:0] wq[$];

  // RAM responder: ack after ack_delay cycles of ram_req
  initial forever begin
    @(posedge clk_sys); #1;
    if (ram_req) begin
      ram_ack = (ack_cnt == ack_delay);
      ack_cnt++;
    end else begin
      ram_ack = 1'b0;
      ack_cnt = 0;
    end
  end

  // Write logger and wait monitor
  always @(negedge clk_sys) begin
    if (ram_req && ram_ack) wq.push_back({ram_addr, ram_data});
    if (ioctl_wait) wait_hi++;
    if (ram_req && !ioctl_wait) viol++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk_sys); #1; end
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    int g;
    g = 0;
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    while (ioctl_wait && g < 100) begin @(posedge clk_sys); #1; g++; end
    if (g >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: wait still %0b expected 0", ioctl_wait);
    end
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (ram_req && g < 100) begin @(posedge clk_sys); #1; g++; end
    if (g >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: ram_req still %0b expected 0", ram_req);
    end
  endtask

  task automatic begin_dl(input logic [7:0] idx);
    ioctl_index = idx; ioctl_download = 1'b1;
    tick(2);
  endtask

  task automatic end_dl();
    drain();
    ioctl_download = 1'b0;
    tick(3);
  endtask

  task automatic send_img(input bq_t img);
    for (int i = 0; i < img.size(); i++) send_byte(25'(i), img[i]);
    drain();
  endtask

  vec_t tv[9];

  initial begin
    int bad;
    int hi_bad;
    bq_t img;

    tv[0] = '{8'h02, 0, 24'h0,      1'b1};
    tv[1] = '{8'h00, 0, 24'h0,      1'b1};
    tv[2] = '{8'h03, 0, 24'h0,      1'b1};
    tv[3] = '{8'hAA, 1, 24'h0200AA, 1'b1};
    tv[4] = '{8'hBB, 1, 24'h0201BB, 1'b1};
    tv[5] = '{8'hCC, 1, 24'h0202CC, 1'b1};
    tv[6] = '{8'h00, 0, 24'h0,      1'b1};
    tv[7] = '{8'h02, 0, 24'h0,      1'b1};
    tv[8] = '{8'h00, 0, 24'h0,      1'b0};

    // Reset state
    tick(3);
    chk("reset_outputs", {ioctl_wait, ram_req, ram_addr, ram_data, start_addr,
                          start_valid, busy, error}, 64'h0);
    reset = 1'b0;
    tick(2);

    // Minimal image, table-driven, ack in same cycle as req
    ack_delay = 0;
    begin_dl(8'h01);
    chk("min_busy_start", busy, 1);
    for (int i = 0; i < 9; i++) begin
      wq.delete();
      send_byte(25'(i), tv[i].b);
      drain();
      chk($sformatf("min_nwr_%0d", i), wq.size(), tv[i].nwr);
      if (tv[i].nwr == 1) chk($sformatf("min_wr_%0d", i), wq[0], tv[i].wr);
      chk($sformatf("min_busy_%0d", i), busy, tv[i].busy);
    end
    chk("min_start_addr", start_addr, 16'h0200);
    chk("min_flags", {start_valid, error}, 2'b10);
    wq.delete();
    send_byte(25'd9, 8'h77);
    drain();
    chk("min_done_ignores", wq.size(), 0);
    end_dl();
    chk("min_valid_held", start_valid, 1);

    // Size 0 and page wrap
    wq.delete();
    begin_dl(8'h01);
    img = '{8'h05, 8'hFE, 8'h00};
    for (int i = 0; i < 256; i++) img.push_back(8'(i));
    img.push_back(8'h00); img.push_back(8'h12); img.push_back(8'h34);
    send_img(img);
    chk("wrap_count", wq.size(), 256);
    chk("wrap_first", wq[0], 24'h05FE00);
    chk("wrap_last", wq[255], 24'h05FDFF);
    bad = 0; hi_bad = 0;
    for (int i = 0; i < wq.size(); i++) begin
      if (wq[i] !== {8'h05, 8'(8'hFE + i), 8'(i)}) bad++;
      if (wq[i][23:16] !== 8'h05) hi_bad++;
    end
    chk("wrap_all_writes", bad, 0);
    chk("wrap_page_fixed", hi_bad, 0);
    chk("wrap_start", {start_valid, start_addr}, {1'b1, 16'h1234});
    end_dl();

    // Back-pressure: ack 5 cycles late
    ack_delay = 5;
    wq.delete();
    begin_dl(8'h01);
    wait_hi = 0; viol = 0;
    send_img('{8'h10, 8'h80, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04,
               8'h00, 8'hAB, 8'hCD});
    chk("bp_count", wq.size(), 4);
    chk("bp_order", {wq[0], wq[1], wq[2], wq[3]},
        {24'h108001, 24'h108102, 24'h108203, 24'h108304});
    chk("bp_wait_cycles", wait_hi, 24);
    chk("bp_wait_with_req", viol, 0);
    chk("bp_start", {start_valid, start_addr}, {1'b1, 16'hABCD});
    end_dl();
    ack_delay = 0;

    // Zero-page first segment
    wq.delete();
    begin_dl(8'h01);
    send_img('{8'h00, 8'h30, 8'h01, 8'h7F, 8'h00, 8'h11, 8'h22});
    chk("zp_count", wq.size(), 1);
    chk("zp_write", wq[0], 24'h00307F);
    chk("zp_start", {start_valid, error, start_addr}, {2'b10, 16'h1122});
    end_dl();

    // Truncation with the last write still outstanding
    ack_delay = 3;
    wq.delete();
    begin_dl(8'h01);
    send_byte(25'd0, 8'h02); send_byte(25'd1, 8'h00);
    send_byte(25'd2, 8'h03); send_byte(25'd3, 8'hAA);
    chk("trunc_req_out", ram_req, 1);
    ioctl_download = 1'b0;
    tick(1);
    chk("trunc_not_yet", error, 0);
    drain();
    tick(2);
    chk("trunc_count", wq.size(), 1);
    chk("trunc_write", wq[0], 24'h0200AA);
    chk("trunc_flags", {error, start_valid, busy}, 3'b100);
    ack_delay = 0;

    // Foreign index: ignored, ERROR state retained
    wq.delete();
    begin_dl(8'h02);
    send_img('{8'h02, 8'h00, 8'h01, 8'h99});
    chk("idx_no_writes", wq.size(), 0);
    chk("idx_state_kept", {error, start_valid, busy}, 3'b100);
    end_dl();
    chk("idx_after_end", error, 1);

    // Address mismatch forces ERROR
    begin_dl(8'h01);
    chk("addr_cleared", {error, busy}, 2'b01);
    send_byte(25'd0, 8'h02);
    send_byte(25'd3, 8'h00);
    chk("addr_mismatch", {error, start_valid, busy}, 3'b100);
    end_dl();

    // Restart mid-parse by re-raising the index match
    wq.delete();
    begin_dl(8'h01);
    send_img('{8'h02, 8'h00, 8'h05, 8'hAA, 8'hBB});
    chk("rs_partial", wq.size(), 2);
    ioctl_index = 8'h02;
    tick(1);
    ioctl_index = 8'h01;
    tick(2);
    chk("rs_busy", {busy, error}, 2'b10);
    wq.delete();
    send_img('{8'h03, 8'h00, 8'h01, 8'h55, 8'h00, 8'h00, 8'h40});
    chk("rs_count", wq.size(), 1);
    chk("rs_write", wq[0], 24'h030055);
    chk("rs_start", {start_valid, error, start_addr}, {2'b10, 16'h0040});
    end_dl();

    // Reset mid-DATA with a write outstanding
    ack_delay = 5;
    begin_dl(8'h01);
    send_byte(25'd0, 8'h02); send_byte(25'd1, 8'h00);
    send_byte(25'd2, 8'h03); send_byte(25'd3, 8'hAA);
    chk("rst_req_out", ram_req, 1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    @(posedge clk_sys); #1;
    chk("rst_outputs", {ioctl_wait, ram_req, ram_addr, ram_data, start_addr,
                        start_valid, busy, error}, 64'h0);
    reset = 1'b0;
    ack_delay = 0;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
